mux8way_rr: RTL and testbench
=============================

Name: mux8way_rr

Overview:
- 8-to-1 round-robin gather multiplexer. It is the reverse of the 1-to-8 demultiplexer: eight producer lanes (a..h) merge onto one registered output stream.
- Each lane has a valid/ready handshake. The output carries the data word plus the 3-bit index of the source lane.
- The demux can use that `saida_sel` tag downstream to scatter the word back, so the pair forms a scatter/gather path.

Parameters:
- WIDTH, default 8, data word width per lane and at the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  8  bit k = lane k offers a word (bit 0 = lane a ... bit 7 = lane h)
- in_data  input  8*WIDTH  lane k word at bits [k*WIDTH +: WIDTH]
- in_ready  output  8  bit k = lane k word accepted this cycle; one-hot or zero
- saida  output  WIDTH  registered output word
- saida_sel  output  3  index of the lane that supplied saida
- saida_valid  output  1  saida/saida_sel hold a valid word
- saida_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Reset: asynchronous, active-high. While rst=1, and on the first edge after release:
  - saida=0, saida_sel=0, saida_valid=0
  - round-robin pointer ptr=0
  - in_ready=0 while rst=1
- Internal state:
  - output register (saida, saida_sel, saida_valid)
  - 3-bit ptr = highest-priority lane for the next grant
- Load enable, combinational: `load = !saida_valid | saida_ready`.
- Grant, combinational:
  - Search in_valid starting at lane ptr, ascending, wrapping 7→0.
  - The first lane k with in_valid[k]=1 is granted.
  - `in_ready[k] = load & granted(k)`; all other bits are 0.
  - in_ready depends on in_valid only through the arbiter, never on in_data.
- Transfer on lane k: in_valid[k] & in_ready[k]. On that edge:
  - saida <= in_data lane k
  - saida_sel <= k
  - saida_valid <= 1
  - ptr <= (k+1) mod 8, so lane 7 → ptr 0
- Load with no in_valid bit set:
  - If the consumer takes the current word, saida_valid <= 0.
  - saida and saida_sel keep their values; ptr is unchanged.
- Stall, saida_valid=1 & saida_ready=0:
  - saida, saida_sel and saida_valid hold.
  - in_ready=0 and ptr holds.
- Simultaneous consume and refill (saida_valid=1, saida_ready=1, some in_valid set): new word loaded on the same edge, no bubble. Full throughput is one word per cycle.
- Timing:
  - Latency is 1 cycle: a word accepted at edge N is visible on saida after edge N.
  - Fairness: a lane holding in_valid=1 is granted within 8 loads.
- Lane-side rule: a lane may drop in_valid without a transfer; the block tolerates this, and grant is recomputed every cycle.
- Reset mid-operation: a pending output word is discarded immediately and ptr returns to 0.
- No X propagation: saida_sel is always a defined 3-bit value.

Test Plan:
- Reset/idle: assert rst mid-stream with saida_valid=1 → saida_valid=0, saida=0, saida_sel=0, in_ready=8'h00 immediately; ptr=0 after release.
- Single lane:
  - Stimulus: saida_ready=1; in_valid=8'b0000_0100, lane c data=8'hA5 for one cycle.
  - Response: in_ready=8'b0000_0100 that cycle; next cycle saida=8'hA5, saida_sel=2, saida_valid=1.
  - Following cycle, with in_valid=0: saida_valid=0.
- Round-robin rotation:
  - Stimulus: all in_valid=8'hFF, lane k data=8'h10+k, saida_ready=1 for 10 cycles.
  - Response: saida_sel sequence 0,1,2,...,7,0,1; saida=8'h10..8'h17,8'h10,8'h11; saida_valid continuously 1.
- Fairness/wrap:
  - Stimulus: after a grant of lane 6 (ptr=7), in_valid=8'b1000_0011.
  - Response: grants in order 7, 0, 1.
- Backpressure:
  - Stimulus: saida_valid=1 with saida=8'h33, saida_sel=3; saida_ready=0 for 4 cycles while in_valid=8'hFF.
  - Response: outputs unchanged, in_ready=0, ptr unchanged.
  - Then saida_ready=1 → the next lane after ptr loads on the same edge as the consume.
- Drop-out: lane e asserts in_valid for one cycle while stalled and then drops it → no transfer from lane e; that word never appears on saida.

Source files
------------

// File: rtl/mux8way_rr.sv
// Eight valid/ready lanes gathered round-robin onto one registered output with a source-lane tag.
// Latency 1 cycle; a stalled output (saida_valid & !saida_ready) clears in_ready and freezes the pointer.
module mux8way_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic [WIDTH-1:0]   saida,
  output logic [2:0]         saida_sel,
  output logic               saida_valid,
  input  logic               saida_ready
);

  logic [2:0] ptr;
  logic       load;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [2:0] cand;

  assign load = !saida_valid | saida_ready;

  // Walk offsets from the far end back to ptr so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    cand    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    in_ready = 8'h00;
    if (load && gnt_vld && !rst) begin
      in_ready = 8'h01 << gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida       <= '0;
      saida_sel   <= 3'd0;
      saida_valid <= 1'b0;
      ptr         <= 3'd0;
    end else if (load) begin
      if (gnt_vld) begin
        saida       <= in_data[gnt_idx*WIDTH +: WIDTH];
        saida_sel   <= gnt_idx;
        saida_valid <= 1'b1;
        ptr         <= gnt_idx + 3'd1;
      end else begin
        saida_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8way_rr.sv
// Table-driven directed vectors plus randomized traffic against a distance-based round-robin model.
module tb_mux8way_rr;

  logic        clk;
  logic        rst;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic [7:0]  saida;
  logic [2:0]  saida_sel;
  logic        saida_valid;
  logic        saida_ready;

  mux8way_rr #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .saida(saida), .saida_sel(saida_sel), .saida_valid(saida_valid),
    .saida_ready(saida_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: output register contents and the lane that has top priority.
  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  int         m_ptr;

  // Winner is the requesting lane with the smallest forward distance from the pointer.
  function automatic int pick(input logic [7:0] v, input int p);
    int best = -1;
    int bd = 99;
    for (int k = 0; k < 8; k++) begin
      if (v[k] && ((k - p + 8) % 8) < bd) begin
        best = k;
        bd = (k - p + 8) % 8;
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] model_ready(input logic [7:0] v, input logic r);
    int w;
    w = pick(v, m_ptr);
    if ((!m_valid || r) && w >= 0) return 8'(1 << w);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_sel = 3'd0; m_ptr = 0;
  endtask

  task automatic model_edge(input logic [7:0] v, input logic [63:0] d, input logic r);
    int w;
    if (!m_valid || r) begin
      w = pick(v, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = d[w*8 +: 8];
        m_sel   = 3'(w);
        m_ptr   = (w + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  logic [7:0] samp_rdy;
  logic [7:0] pred_rdy;

  task automatic cycle(input logic [7:0] v, input logic [63:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; saida_ready = r;
    #1;
    samp_rdy = in_ready;
    pred_rdy = model_ready(v, r);
    @(posedge clk);
    model_edge(v, d, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 8'h00; saida_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          pre_rst;
    logic [7:0]  v;
    logic [63:0] d;
    logic        r;
    logic [7:0]  e_rdy;
    logic [7:0]  e_saida;
    logic [2:0]  e_sel;
    logic        e_vld;
  } tv_t;

  tv_t tab[$];

  localparam logic [63:0] D0   = 64'h17161514_13121110;
  localparam logic [63:0] D_A5 = 64'h17161514_13A51110;
  localparam logic [63:0] D_33 = 64'h17161514_33121110;
  localparam logic [63:0] D_EE = 64'h171615EE_13121110;

  initial begin
    int k;
    logic [7:0] rv;
    logic [63:0] rd;
    logic rr;

    rst = 1'b1; in_valid = 8'h00; in_data = D0; saida_ready = 1'b0;
    model_reset();

    // Single lane, then idle drains the output.
    tab.push_back('{0, 8'h04, D_A5, 1'b1, 8'h04, 8'hA5, 3'd2, 1'b1});
    tab.push_back('{0, 8'h00, D0,   1'b1, 8'h00, 8'hA5, 3'd2, 1'b0});
    // Full rotation from a fresh pointer.
    for (int i = 0; i < 10; i++) begin
      k = i % 8;
      tab.push_back('{(i == 0), 8'hFF, D0, 1'b1, 8'(1 << k), 8'(8'h10 + k), 3'(k), 1'b1});
    end
    // Lane 6 then wrap across 7 -> 0 -> 1.
    tab.push_back('{0, 8'h40, D0, 1'b1, 8'h40, 8'h16, 3'd6, 1'b1});
    tab.push_back('{0, 8'h83, D0, 1'b1, 8'h80, 8'h17, 3'd7, 1'b1});
    tab.push_back('{0, 8'h83, D0, 1'b1, 8'h01, 8'h10, 3'd0, 1'b1});
    tab.push_back('{0, 8'h83, D0, 1'b1, 8'h02, 8'h11, 3'd1, 1'b1});
    // Backpressure with lane e dropping out mid-stall.
    tab.push_back('{0, 8'h08, D_33, 1'b1, 8'h08, 8'h33, 3'd3, 1'b1});
    tab.push_back('{0, 8'hFF, D0,   1'b0, 8'h00, 8'h33, 3'd3, 1'b1});
    tab.push_back('{0, 8'h10, D_EE, 1'b0, 8'h00, 8'h33, 3'd3, 1'b1});
    tab.push_back('{0, 8'h00, D0,   1'b0, 8'h00, 8'h33, 3'd3, 1'b1});
    tab.push_back('{0, 8'hFF, D0,   1'b0, 8'h00, 8'h33, 3'd3, 1'b1});
    tab.push_back('{0, 8'hFF, D0,   1'b1, 8'h10, 8'h14, 3'd4, 1'b1});
    tab.push_back('{0, 8'h00, D0,   1'b1, 8'h00, 8'h14, 3'd4, 1'b0});

    #1;
    chk("rst_in_ready", in_ready, 8'h00);
    chk("rst_saida", saida, 8'h00);
    chk("rst_sel", saida_sel, 3'd0);
    chk("rst_valid", saida_valid, 1'b0);
    do_reset();

    foreach (tab[i]) begin
      if (tab[i].pre_rst) do_reset();
      cycle(tab[i].v, tab[i].d, tab[i].r);
      chk($sformatf("tab%0d_in_ready", i), samp_rdy, tab[i].e_rdy);
      chk($sformatf("tab%0d_saida", i), saida, tab[i].e_saida);
      chk($sformatf("tab%0d_sel", i), saida_sel, tab[i].e_sel);
      chk($sformatf("tab%0d_valid", i), saida_valid, tab[i].e_vld);
    end

    // Reset asserted while a word is pending and being stalled.
    cycle(8'hFF, D0, 1'b0);
    cycle(8'hFF, D0, 1'b0);
    chk("pre_rst_valid", saida_valid, 1'b1);
    @(negedge clk);
    in_valid = 8'hFF; rst = 1'b1;
    #1;
    chk("mid_rst_valid", saida_valid, 1'b0);
    chk("mid_rst_saida", saida, 8'h00);
    chk("mid_rst_sel", saida_sel, 3'd0);
    chk("mid_rst_in_ready", in_ready, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(8'hFE, D0, 1'b1);
    chk("post_rst_in_ready", samp_rdy, 8'h02);
    chk("post_rst_sel", saida_sel, 3'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rd = {$urandom(), $urandom()};
      rr = ($urandom_range(0, 3) != 0);
      cycle(rv, rd, rr);
      chk("rnd_in_ready", samp_rdy, pred_rdy);
      chk("rnd_valid", saida_valid, m_valid);
      if (m_valid) begin
        chk("rnd_saida", saida, m_data);
        chk("rnd_sel", saida_sel, m_sel);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
